// File: rtl/wheelsize_config_pkg.sv
// Shared constants and types for the wheel-circumference setting block:
// edit-buffer geometry, accepted range and the reset default.
package wheel_pkg;
  localparam int DIGITS     = 4;
  localparam int CUR_W      = $clog2(DIGITS);
  localparam int MM_W       = $clog2(10**DIGITS);
  localparam int BCD_W      = 4 * DIGITS;
  localparam int DEFAULT_MM = 2136;
  localparam int MIN_MM     = 500;
  localparam int MAX_MM     = 3000;
  localparam int BLINK_HALF = 2560;

  typedef enum logic [1:0] {IDLE, EDIT, CONVERT, CHECK} wheel_state_t;
  typedef logic [3:0]       bcd_digit_t;
  typedef logic [BCD_W-1:0] bcd_word_t;
  typedef logic [MM_W-1:0]  mm_t;
  typedef logic [CUR_W-1:0] cursor_t;

  function automatic bcd_word_t mm_to_bcd(input int unsigned mm);
    bcd_word_t   w;
    int unsigned v;
    w = '0;
    v = mm;
    for (int i = 0; i < DIGITS; i++) begin
      w[4*i +: 4] = bcd_digit_t'(v % 10);
      v = v / 10;
    end
    return w;
  endfunction

  localparam bcd_word_t DEFAULT_BCD = mm_to_bcd(DEFAULT_MM);

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction
endpackage

// File: rtl/wheelsize_config_if.sv
// Menu/edit strobes from the button front-end plus the display and
// datapath outputs of the wheelsize setting block.
interface wheelsize_config_if;
  import wheel_pkg::*;

  logic      wheelsize_menu;
  logic      wheelsize_digit_change;
  logic      wheelsize_value_change;
  bcd_word_t edit_bcd;
  cursor_t   cursor;
  logic      blink;
  logic      editing;
  mm_t       wheel_mm;
  logic      wheel_update;
  logic      wheel_reject;

  modport master (
    output wheelsize_menu, wheelsize_digit_change, wheelsize_value_change,
    input  edit_bcd, cursor, blink, editing, wheel_mm, wheel_update, wheel_reject
  );

  modport slave (
    input  wheelsize_menu, wheelsize_digit_change, wheelsize_value_change,
    output edit_bcd, cursor, blink, editing, wheel_mm, wheel_update, wheel_reject
  );
endinterface

// File: rtl/wheelsize_config_blink_gen.sv
// Cursor blink generator: restarts high on clear, toggles every HALF enabled
// cycles, and sits low while disabled.
module blink_gen #(
  parameter int HALF = 2560
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clr_i,
  input  logic en_i,
  output logic blink_o
);
  localparam int CNT_W = $clog2(HALF);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;

  always_comb begin
    cnt_d   = cnt_q;
    blink_d = blink_q;
    if (clr_i) begin
      cnt_d   = '0;
      blink_d = 1'b1;
    end else if (!en_i) begin
      cnt_d   = '0;
      blink_d = 1'b0;
    end else if (cnt_q == CNT_W'(HALF - 1)) begin
      cnt_d   = '0;
      blink_d = ~blink_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      blink_q <= blink_d;
    end
  end

  assign blink_o = blink_q;
endmodule

// File: rtl/wheelsize_config.sv
// Wheel-circumference setting: BCD edit buffer with cursor/blink, sequential
// BCD-to-binary conversion on menu exit, range check, commit or reject.
module wheelsize_config
  import wheel_pkg::*;
(
  input  logic         Clock,
  input  logic         Reset,
  wheelsize_config_if.slave bus,
  output wheel_state_t state_o
);
  wheel_state_t state_q, state_d;
  logic         menu_q;
  bcd_word_t    edit_q, edit_d;
  bcd_word_t    active_q, active_d;
  cursor_t      cursor_q, cursor_d;
  cursor_t      idx_q, idx_d;
  mm_t          acc_q, acc_d;
  mm_t          wheel_mm_q, wheel_mm_d;
  logic         update_q, update_d;
  logic         reject_q, reject_d;
  logic         blink_clr;
  logic         blink;
  logic         menu_rise, menu_fall;
  bcd_digit_t   conv_digit;

  assign menu_rise = bus.wheelsize_menu & ~menu_q;
  assign menu_fall = ~bus.wheelsize_menu & menu_q;

  // Cursor 0 is the most significant digit, which lives in the top nibble.
  always_comb begin
    conv_digit = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == DIGITS - 1 - int'(idx_q)) conv_digit = edit_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d    = state_q;
    edit_d     = edit_q;
    active_d   = active_q;
    cursor_d   = cursor_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    wheel_mm_d = wheel_mm_q;
    update_d   = 1'b0;
    reject_d   = 1'b0;
    blink_clr  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (menu_rise) begin
          edit_d    = active_q;
          cursor_d  = '0;
          blink_clr = 1'b1;
          state_d   = EDIT;
        end
      end
      EDIT: begin
        if (menu_fall) begin
          acc_d   = '0;
          idx_d   = '0;
          state_d = CONVERT;
        end else begin
          for (int i = 0; i < DIGITS; i++) begin
            if (bus.wheelsize_value_change && (i == DIGITS - 1 - int'(cursor_q)))
              edit_d[4*i +: 4] = bcd_inc(edit_q[4*i +: 4]);
          end
          if (bus.wheelsize_digit_change)
            cursor_d = (cursor_q == cursor_t'(DIGITS - 1)) ? '0 : cursor_q + cursor_t'(1);
        end
      end
      CONVERT: begin
        acc_d = acc_q * mm_t'(10) + mm_t'(conv_digit);
        idx_d = idx_q + cursor_t'(1);
        if (idx_q == cursor_t'(DIGITS - 1)) state_d = CHECK;
      end
      CHECK: begin
        if ((acc_q >= mm_t'(MIN_MM)) && (acc_q <= mm_t'(MAX_MM))) begin
          wheel_mm_d = acc_q;
          active_d   = edit_q;
          update_d   = 1'b1;
        end else begin
          edit_d   = active_q;
          reject_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      menu_q     <= 1'b0;
      edit_q     <= DEFAULT_BCD;
      active_q   <= DEFAULT_BCD;
      cursor_q   <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      wheel_mm_q <= mm_t'(DEFAULT_MM);
      update_q   <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      menu_q     <= bus.wheelsize_menu;
      edit_q     <= edit_d;
      active_q   <= active_d;
      cursor_q   <= cursor_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      wheel_mm_q <= wheel_mm_d;
      update_q   <= update_d;
      reject_q   <= reject_d;
    end
  end

  blink_gen #(.HALF(BLINK_HALF)) u_blink (
    .Clock   (Clock),
    .Reset   (Reset),
    .clr_i   (blink_clr),
    .en_i    (state_d == EDIT),
    .blink_o (blink)
  );

  assign bus.edit_bcd     = edit_q;
  assign bus.cursor       = cursor_q;
  assign bus.blink        = blink;
  assign bus.editing      = (state_q == EDIT);
  assign bus.wheel_mm     = wheel_mm_q;
  assign bus.wheel_update = update_q;
  assign bus.wheel_reject = reject_q;
  assign state_o          = state_q;
endmodule
